priority_grant_scheduler: RTL and testbench
===========================================

// Module: priority_grant_scheduler
// PURPOSE
//  Shares one service resource among 12 requesters (board switches or buttons) by fixed priority.
//  Inputs are synchronised and edge-detected. Each rising edge is latched as a pending request.
//  Pending requests are served one at a time, highest index first. Each grant holds until the
//  requester signals done or a timeout expires.
//  grant_id and next_id use the 1..12 code (0 = none) and drive the two hex-to-seven-segment digits.
// PARAMETERS
//  N_REQ      12  number of requesters (fixed by the package; do not override)
//  SVC_CYCLES 50  maximum grant length in clk cycles; range 1..65535
//  MAX_SKIP   4   AGING_EN only: grants a pending request may be bypassed before it is forced
// PORTS
//  clk       in   1   system clock
//  reset_n   in   1   asynchronous, active-low reset
//  req       in   12  raw request levels; bit i = requester i; asynchronous to clk
//  done      in   1   current grantee releases the resource; sampled only in GRANT
//  grant     out  12  one-hot grant; all zero when not granting
//  grant_id  out  4   granted index+1 (1..12); 0 when not granting
//  next_id   out  4   highest pending index+1 excluding the grantee; 0 if nothing pending
//  busy      out  1   1 while in GRANT or GAP
//  overflow  out  1   sticky; set when a rising edge arrives on an already-pending bit
// BEHAVIOUR
//  - Reset (async assert, sync release): sync flops = 0, pending = 0, state = IDLE, counter = 0.
//    All outputs reset to 0.
//  - Input path: 2-flop synchroniser, then a rising-edge detector. An edge sets pending[i] one
//    cycle later. Edge-to-pending latency is 3 cycles. Held levels do not re-trigger.
//  - Priority: bit 11 highest, bit 0 lowest. A pending bit clears in the cycle its grant is issued.
//    An edge on the same bit in that same cycle re-sets the bit (set wins over clear).
//  - FSM:
//    - IDLE: if pending != 0, load the winner into the grant register, clear its pending bit and
//      go to GRANT. grant is visible one cycle after pending was seen.
//    - GRANT: the counter increments from 0. Leave when done = 1 or counter = SVC_CYCLES-1, then
//      go to GAP. grant drops on the transition edge.
//    - GAP: exactly 1 cycle with all grant outputs 0, then go to IDLE.
//  - Back-to-back: with requests pending, consecutive grants are separated by exactly 2 idle
//    cycles (GAP, then IDLE).
//  - done outside GRANT is ignored. done in the first GRANT cycle gives a 1-cycle grant.
//  - next_id is combinational from pending and the current grant register. It is 0 when
//    pending = 0.
//  - overflow: once set, it stays set until reset.
//  - Counter is 16 bits. No wrap is possible, because the exit condition fires at SVC_CYCLES-1.
//  - Reset asserted mid-GRANT: grant drops asynchronously and all pending requests are lost.
// CONFIGURATION
//  - Macro PRIORITY_SCHED_AGING_EN, when defined:
//    - Each pending bit has a 3-bit skip counter.
//    - The counter increments each time another request is granted while this bit stays pending.
//    - When the counter reaches MAX_SKIP, that bit wins the next arbitration regardless of
//      priority. If several bits are forced, the highest forced index wins.
//    - The counter clears when the bit is granted.
//  - Macro not defined: the skip counters are absent and priority is strictly fixed, so
//    starvation of low indices is allowed.
// STRUCTURE
//  - Package priority_sched_pkg:
//    - N_REQ = 12, ID_W = 4, ID_NONE = 4'd0.
//    - State encoding IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2.
//    - Function idx_to_id(i) = i+1.
//  - Sub-module pri_top2_pick is purely combinational:
//    - Input vector[11:0]; outputs first_id and second_id, using the same 0/1..12 code.
//    - Instantiated once for arbitration (on pending, or on the forced vector under aging).
//    - Instantiated once for next_id.
//  - Top holds the synchroniser, edge detector, pending register, FSM, counter and overflow.
// TESTING
//  1. Reset: hold reset_n = 0 with req = 12'hFFF. Required: grant = 0, grant_id = 0, busy = 0,
//     overflow = 0. After release, the first grant is bit 11 (grant_id = 12).
//  2. Simultaneous edges: req 0 -> 12'h0A4 in one cycle, done never asserted, SVC_CYCLES = 5.
//     Required grant order is ids 8, 6, 3, each grant exactly 5 cycles with 2-cycle gaps.
//     next_id reads 6, then 3, then 0.
//  3. Early release: grant id 5 active, pulse done in grant cycle 2. Required: grant = 0 on the
//     next cycle, busy = 1 for one GAP cycle, then busy = 0.
//  4. Overflow: edge on bit 3, release it, edge again while bit 3 is pending but not granted.
//     Required: overflow = 1 and it stays 1. Bit 3 is granted once only.
//  5. Mid-grant reset: assert reset_n low in grant cycle 2 of id 10 with bit 1 pending.
//     Required: grant = 0 immediately. After release with req held static, no grant occurs.
//  6. Aging (PRIORITY_SCHED_AGING_EN, MAX_SKIP = 4): bit 0 pending while bits 11 and 10 keep
//     re-pending. Required: bit 0 is granted as the 5th grant, not later. Without the macro,
//     bit 0 is never granted.

Source files
------------

// File: rtl/priority_sched_pkg.sv
// priority_sched_pkg: shared sizes, FSM encoding and the 1..12 id code helper.
package priority_sched_pkg;
  localparam int N_REQ = 12;
  localparam int ID_W = 4;
  localparam logic [ID_W-1:0] ID_NONE = 4'd0;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;
  function automatic logic [ID_W-1:0] idx_to_id(input int i);
    return ID_W'(i + 1);
  endfunction
endpackage

// File: rtl/pri_top2_pick.sv
// pri_top2_pick: ids (1..12, 0 = none) of the highest and second-highest set bits of a vector.
module pri_top2_pick
  import priority_sched_pkg::*;
(
  input  logic [N_REQ-1:0] vector,
  output logic [ID_W-1:0]  first_id,
  output logic [ID_W-1:0]  second_id
);
  always_comb begin
    first_id = ID_NONE;
    second_id = ID_NONE;
    for (int i = 0; i < N_REQ; i++)
      if (vector[i]) begin
        second_id = first_id;
        first_id = idx_to_id(i);
      end
  end
endmodule

// File: rtl/priority_grant_scheduler.sv
// priority_grant_scheduler: fixed-priority single-resource scheduler for 12 async requesters.
// Define PRIORITY_SCHED_AGING_EN to add per-request skip counters that force starved requests.
module priority_grant_scheduler
  import priority_sched_pkg::*;
#(
  parameter int SVC_CYCLES = 50
`ifdef PRIORITY_SCHED_AGING_EN
  , parameter int MAX_SKIP = 4
`endif
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic [ID_W-1:0]  next_id,
  output logic             busy,
  output logic             overflow
);
  state_t r_state;
  logic [N_REQ-1:0] r_sync1, r_sync2, r_prev, r_pending, r_grant;
  logic [ID_W-1:0] r_grant_id;
  logic [15:0] r_cnt;
  logic r_busy, r_overflow;
  logic [N_REQ-1:0] w_rise, w_arb_vec, w_win_oh, w_clr;
  logic [ID_W-1:0] w_win_id, w_unused_arb_second, w_nx_first, w_nx_second;
  logic w_take, w_exit;
  assign w_rise = r_sync2 & ~r_prev;
  assign w_take = (r_state == IDLE) && (r_pending != '0);
  assign w_exit = done || (r_cnt == 16'(SVC_CYCLES - 1));
  assign w_win_oh = (w_win_id == ID_NONE) ? '0 : N_REQ'(1) << (w_win_id - ID_W'(1));
  assign w_clr = w_take ? w_win_oh : '0;
`ifdef PRIORITY_SCHED_AGING_EN
  logic [2:0] r_skip [N_REQ];
  logic [N_REQ-1:0] w_forced;
  for (genvar i = 0; i < N_REQ; i++) begin : g_forced
    assign w_forced[i] = r_pending[i] && (r_skip[i] >= 3'(MAX_SKIP));
  end
  assign w_arb_vec = (w_forced != '0) ? w_forced : r_pending;
  // a request is bypassed whenever another one wins while it is pending
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < N_REQ; i++) r_skip[i] <= '0;
    else if (w_take)
      for (int i = 0; i < N_REQ; i++)
        r_skip[i] <= (w_win_oh[i] || !r_pending[i]) ? 3'd0 :
                     (r_skip[i] >= 3'(MAX_SKIP)) ? r_skip[i] : r_skip[i] + 3'd1;
`else
  assign w_arb_vec = r_pending;
`endif
  pri_top2_pick u_arb (.vector(w_arb_vec), .first_id(w_win_id), .second_id(w_unused_arb_second));
  pri_top2_pick u_next (.vector(r_pending | r_grant), .first_id(w_nx_first), .second_id(w_nx_second));
  // the grantee is in the vector, so skip it when it is the top entry
  assign next_id = (r_grant_id != ID_NONE && w_nx_first == r_grant_id) ? w_nx_second : w_nx_first;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev <= '0;
      r_pending <= '0;
      r_grant <= '0;
      r_grant_id <= ID_NONE;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_overflow <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_sync1 <= req;
      r_sync2 <= r_sync1;
      r_prev <= r_sync2;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_overflow <= r_overflow | (|(w_rise & r_pending));
      case (r_state)
        IDLE: if (w_take) begin
          r_state <= GRANT;
          r_grant <= w_win_oh;
          r_grant_id <= w_win_id;
          r_busy <= 1'b1;
          r_cnt <= '0;
        end
        GRANT: if (w_exit) begin
          r_state <= GAP;
          r_grant <= '0;
          r_grant_id <= ID_NONE;
          r_cnt <= '0;
        end else r_cnt <= r_cnt + 16'd1;
        GAP: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign grant = r_grant;
  assign grant_id = r_grant_id;
  assign busy = r_busy;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_priority_grant_scheduler.sv
// tb_priority_grant_scheduler: vector table plus hand sequences; a grant scoreboard checks order and length.
module tb_priority_grant_scheduler;
  localparam int SVC = 5;
  typedef struct {logic [3:0] id; int len;} exp_t;
  typedef struct {logic [11:0] req; int n; logic [15:0] ids; logic [3:0] nxt;} vec_t;

  logic clk = 1'b0, reset_n = 1'b0, done = 1'b0;
  logic [11:0] req = '0;
  logic [11:0] grant;
  logic [3:0] grant_id, next_id;
  logic busy, overflow;

  int n_chk = 0, n_fail = 0;
  bit sb_en = 1'b1;
  exp_t sb_q[$];
  exp_t cur;
  bit run = 1'b0;
  int run_len = 0;
  logic [3:0] prev_gid = '0;
  vec_t tbl [5];
  logic [3:0] t2_id [3] = '{4'd8, 4'd6, 4'd3};
  logic [3:0] t2_nx [3] = '{4'd6, 4'd3, 4'd0};
`ifdef PRIORITY_SCHED_AGING_EN
  logic [3:0] t6_exp [5] = '{4'd12, 4'd11, 4'd12, 4'd11, 4'd1};
`else
  logic [3:0] t6_exp [5] = '{4'd12, 4'd11, 4'd12, 4'd11, 4'd12};
`endif

  always #5 clk = ~clk;

  priority_grant_scheduler #(.SVC_CYCLES(SVC)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done), .grant(grant),
    .grant_id(grant_id), .next_id(next_id), .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] oh(input logic [3:0] id);
    return (id == 4'd0) ? 12'd0 : 12'd1 << (id - 4'd1);
  endfunction

  function automatic exp_t mk(input logic [3:0] id, input int len);
    exp_t e;
    e.id = id;
    e.len = len;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_gid = '0;
      run = 1'b0;
    end else begin
      chk("onehot", grant, oh(grant_id));
      if (sb_en && grant_id != 0 && prev_gid == 0) begin
        if (sb_q.size() == 0) chk("sb_unexpected", grant_id, 0);
        else begin
          cur = sb_q.pop_front();
          chk("sb_id", grant_id, cur.id);
          run = 1'b1;
          run_len = 0;
        end
      end
      if (grant_id != 0 && prev_gid != 0) chk("sb_nogap", grant_id, prev_gid);
      if (run && grant_id != 0) run_len++;
      if (run && grant_id == 0) begin
        chk("sb_len", run_len, cur.len);
        run = 1'b0;
      end
      prev_gid = grant_id;
    end
  end

  task automatic wait_idle(input string name);
    int c = 0;
    while ((sb_q.size() != 0 || run || busy) && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(name, c < 300, 1);
  endtask

  task automatic next_grant(output logic [3:0] id);
    int c = 0;
    while (grant_id != 0 && c < 100) begin @(negedge clk); c++; end
    while (grant_id == 0 && c < 100) begin @(negedge clk); c++; end
    if (c >= 100) chk("grant_timeout", c, 0);
    id = grant_id;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] id;
    int len, gap;
    tbl[0] = '{12'h801, 2, 16'hC100, 4'd1};
    tbl[1] = '{12'h010, 1, 16'h5000, 4'd0};
    tbl[2] = '{12'h3C0, 4, 16'hA987, 4'd9};
    tbl[3] = '{12'h002, 1, 16'h2000, 4'd0};
    tbl[4] = '{12'h421, 3, 16'hB610, 4'd6};
    // reset with every request high, then all twelve served top-down
    req = 12'hFFF;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_next", next_id, 0);
    for (int i = 12; i >= 1; i--) sb_q.push_back(mk(4'(i), SVC));
    reset_n = 1'b1;
    next_grant(id);
    chk("t1_first", id, 12);
    wait_idle("t1_drain");
    req = '0;
    repeat (3) @(negedge clk);
    chk("t1_ovf", overflow, 0);
    // simultaneous edges: exact lengths, gaps and next_id
    for (int k = 0; k < 3; k++) sb_q.push_back(mk(t2_id[k], SVC));
    req = 12'h0A4;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) next_grant(id);
      else id = grant_id;
      chk("t2_id", id, t2_id[k]);
      chk("t2_next", next_id, t2_nx[k]);
      len = 0;
      while (grant_id != 0 && len < 50) begin len++; @(negedge clk); end
      chk("t2_len", len, SVC);
      chk("t2_gap_busy", busy, 1);
      if (k < 2) begin
        gap = 0;
        while (grant_id == 0 && gap < 50) begin gap++; @(negedge clk); end
        chk("t2_gap", gap, 2);
      end
    end
    @(negedge clk);
    chk("t2_idle_busy", busy, 0);
    req = '0;
    repeat (3) @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < tbl[t].n; j++) sb_q.push_back(mk(tbl[t].ids[15-4*j -: 4], SVC));
      req = tbl[t].req;
      next_grant(id);
      chk("tbl_first", id, tbl[t].ids[15:12]);
      chk("tbl_next", next_id, tbl[t].nxt);
      wait_idle("tbl_drain");
      req = '0;
      repeat (3) @(negedge clk);
    end
    // early release in grant cycle 2
    sb_q.push_back(mk(4'd5, 2));
    req = 12'h010;
    next_grant(id);
    chk("t3_id", id, 5);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("t3_drop", grant, 0);
    chk("t3_gap_busy", busy, 1);
    @(negedge clk);
    chk("t3_idle_busy", busy, 0);
    req = '0;
    repeat (3) @(negedge clk);
    // second edge on bit 3 while it waits behind bit 9
    sb_q.push_back(mk(4'd10, SVC));
    sb_q.push_back(mk(4'd4, SVC));
    req = 12'h208;
    @(negedge clk);
    req = 12'h200;
    repeat (2) @(negedge clk);
    req = 12'h208;
    wait_idle("t4_drain");
    chk("t4_ovf", overflow, 1);
    repeat (10) @(negedge clk);
    chk("t4_ovf_sticky", overflow, 1);
    chk("t4_once", busy, 0);
    req = '0;
    repeat (3) @(negedge clk);
    // reset in grant cycle 2 of id 10 with bit 1 pending
    sb_q.push_back(mk(4'd10, SVC));
    req = 12'h202;
    next_grant(id);
    chk("t5_id", id, 10);
    chk("t5_next", next_id, 2);
    req = '0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_grant_async", grant, 0);
    chk("t5_gid_async", grant_id, 0);
    chk("t5_busy_async", busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("t5_ovf_clr", overflow, 0);
    len = 0;
    repeat (40) begin
      @(negedge clk);
      len += int'(busy);
    end
    chk("t5_no_grant", len, 0);
    // bit 0 competing against alternating re-requests on bits 11 and 10
    sb_en = 1'b0;
    req = 12'h801;
    @(negedge clk);
    req = '0;
    for (int k = 0; k < 5; k++) begin
      next_grant(id);
      chk("t6_order", id, t6_exp[k]);
      if (k < 4) begin
        req = (k % 2 == 0) ? 12'h400 : 12'h800;
        @(negedge clk);
        req = '0;
      end
    end
    len = 0;
    for (int c = 0; c < 200 && len < 5; c++) begin
      @(negedge clk);
      len = busy ? 0 : len + 1;
    end
    chk("t6_drain", len, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
